if_prefetch_unit: RTL and testbench
===================================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; must be a power of two and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr, output, DATA_W, meaning fetch address, held stable while imem_read is high and imem_ready is low.
REQ-007 SHALL have port imem_read, output, 1, meaning fetch request valid.
REQ-008 SHALL have port imem_ready, input, 1, meaning request accepted; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata, input, DATA_W, meaning fetched instruction word.
REQ-010 SHALL have port redirect, input, 1, meaning branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc, input, DATA_W, meaning new fetch address.
REQ-012 SHALL have port id_ready, input, 1, meaning ID accepts an instruction (inverse of ID stall).
REQ-013 SHALL have port id_valid, output, 1, meaning id_inst and id_pc_plus_4 are valid.
REQ-014 SHALL have port id_inst, output, DATA_W, meaning head-of-queue instruction.
REQ-015 SHALL have port id_pc_plus_4, output, DATA_W, meaning address of id_inst plus 4.
REQ-016 SHALL have port q_count, output, $clog2(DEPTH)+1, meaning current queue occupancy.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, FULL: BOOT->FETCH one cycle after reset release; FETCH->FULL when occupancy reaches DEPTH; FULL->FETCH when occupancy drops below DEPTH or redirect is high.
REQ-018 SHALL drive imem_read=1 only in FETCH, with imem_addr=fetch_pc; no combinational path from id_ready to imem_read.
REQ-019 SHALL, on imem_read&imem_ready without redirect, push {imem_rdata, fetch_pc+4} and advance fetch_pc by 4, wrapping modulo 2^DATA_W.
REQ-020 SHALL pop the head entry on id_valid&id_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; id_valid=0 when empty; push never occurs when full.
REQ-022 SHALL, on redirect, empty the queue, set fetch_pc=redirect_pc, discard any word accepted in that cycle, and ignore a simultaneous pop; first new request issues the next cycle.
REQ-023 SHALL, on back-to-back redirects, honour only the latest redirect_pc.
REQ-024 SHALL present a pushed entry on id_inst no earlier than the cycle after the push (1-cycle fetch-to-ID latency) unless REQ-029 applies.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=BOOT, fetch_pc=RESET_PC, pointers=0, q_count=0, imem_read=0, id_valid=0, id_inst=0, id_pc_plus_4=0.
REQ-026 SHALL, on reset assertion mid-transaction, abandon the outstanding request; no entry is pushed.

Configuration
REQ-027 SHALL recognise macro IF_PREFETCH_BYPASS_EN.
REQ-028 SHALL, without the macro, give the fixed 1-cycle latency of REQ-024.
REQ-029 SHALL, with the macro, when the queue is empty, no redirect, and imem_ready=1, forward imem_rdata and fetch_pc+4 combinationally to id_inst and id_pc_plus_4 with id_valid=1; if id_ready=1 the word is consumed and not pushed.

Structure
REQ-030 SHALL take RESET_PC default, FSM state encoding, and state typedef from the shared package if_pkg.
REQ-031 SHALL instantiate a single sub-module inst_fifo (parametrised width 2*DATA_W, depth DEPTH, with flush input) for the queue storage.

Verification
REQ-032 SHALL verify reset: release rst with imem_ready=1 -> first imem_addr=RESET_PC two cycles later; addresses 0,4,8,... follow.
REQ-033 SHALL verify fill: DEPTH=4, id_ready=0, imem_ready=1 -> exactly 4 pushes, q_count=4, state FULL, imem_read=0.
REQ-034 SHALL verify redirect: redirect=1, redirect_pc=32'h100 while queue holds 3 entries -> q_count=0 next cycle, next imem_addr=32'h100, stale words never reach ID.
REQ-035 SHALL verify memory stall: imem_ready=0 for 5 cycles -> imem_addr stable, id_valid=0 once the queue drains, no duplicate or lost PCs.
REQ-036 SHALL verify wrap: fetch_pc=32'hFFFF_FFFC accepted -> id_pc_plus_4=0, next imem_addr=0.
REQ-037 SHALL verify bypass: with IF_PREFETCH_BYPASS_EN, empty queue, imem_ready=1, id_ready=1 -> id_inst=imem_rdata in the same cycle, q_count stays 0; without the macro -> id_valid rises the following cycle.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit: reset PC default
// and the fetch FSM state type.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } if_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Prefetch queue storage: power-of-two circular buffer with a flush input that
// empties it in one cycle. Head entry is visible combinationally on rdata.
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: fetches sequential words into a small queue feeding ID.
// Define IF_PREFETCH_BYPASS_EN to forward a fetched word straight to ID when the queue is empty.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(IF_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [DATA_W-1:0]        imem_addr,
    output logic                     imem_read,
    input  logic                     imem_ready,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [DATA_W-1:0]        redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_inst,
    output logic [DATA_W-1:0]        id_pc_plus_4,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if_state_t         state_reg;
    if_state_t         state_next;
    logic [DATA_W-1:0] fetch_pc_reg;
    logic [DATA_W-1:0] fetch_pc_plus_4;

    logic                fifo_push;
    logic                fifo_pop;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic [CNT_W-1:0]    count_next;

    logic fetch_accept;
    logic head_valid;
    logic bypass_valid;

    // imem_read is a pure function of the state register, so id_ready cannot reach it.
    assign imem_read       = (state_reg == ST_FETCH);
    assign imem_addr       = fetch_pc_reg;
    assign fetch_pc_plus_4 = fetch_pc_reg + DATA_W'(4);
    assign fetch_accept    = imem_read && imem_ready && !redirect;
    assign head_valid      = !fifo_empty;

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass_valid = fetch_accept && fifo_empty;
`else
    assign bypass_valid = 1'b0;
`endif

    // A bypassed word that ID takes right away never enters the queue.
    assign fifo_push = fetch_accept && !fifo_full && !(bypass_valid && id_ready);
    assign fifo_pop  = head_valid && id_ready && !redirect;

    assign id_valid     = head_valid || bypass_valid;
    assign id_inst      = head_valid   ? fifo_rdata[2*DATA_W-1:DATA_W] :
                          bypass_valid ? imem_rdata : '0;
    assign id_pc_plus_4 = head_valid   ? fifo_rdata[DATA_W-1:0] :
                          bypass_valid ? fetch_pc_plus_4 : '0;
    assign q_count      = fifo_count;

    inst_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (fifo_push),
        .wdata ({imem_rdata, fetch_pc_plus_4}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign count_next = redirect ? '0 : (fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (count_next == CNT_W'(DEPTH)) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect || (count_next < CNT_W'(DEPTH))) begin
                    state_next = ST_FETCH;
                end
            end
            default:  state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_BOOT;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            if (redirect) begin
                fetch_pc_reg <= redirect_pc;
            end else if (fetch_accept) begin
                fetch_pc_reg <= fetch_pc_plus_4;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: expected ID stream is the sequential PC
// run from the latest redirect target; a monitor pops and compares every consumed word.
module tb_if_prefetch_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_read;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_inst;
    logic [DATA_W-1:0] id_pc_plus_4;
    logic [CNT_W-1:0]  q_count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [31:0] exp_q[$];

    logic        hold_prev = 1'b0;
    logic [31:0] addr_prev = '0;

    always #5 clk = ~clk;

    if_prefetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_read    (imem_read),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_inst      (id_inst),
        .id_pc_plus_4 (id_pc_plus_4),
        .q_count      (q_count)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] sw;
        sw = {a[15:0], a[31:16]};
        return (a * 32'h9E37_79B1) ^ sw ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: consumed words against the expected stream, plus per-cycle properties.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst === 1'b1) begin
            if (id_valid && id_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected: got pc_plus_4 %h, expected no word", id_pc_plus_4);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc_plus_4", id_pc_plus_4, e + 32'd4);
                    chk("id_inst", id_inst, mem_word(e));
                    pops++;
                    $display("id consume pc=%h inst=%h q_count=%0d", e, id_inst, q_count);
                end
            end
            checks++;
            if (32'(q_count) > 32'(DEPTH)) begin
                errors++;
                $display("FAIL q_count_bound: got %0d, expected <= %0d", q_count, DEPTH);
            end
            if (32'(q_count) == 32'(DEPTH)) begin
                chk("full_no_read", 32'(imem_read), 32'd0);
            end
            if (hold_prev) begin
                chk("addr_hold", imem_addr, addr_prev);
            end
        end
        hold_prev = (rst === 1'b1) && imem_read && !imem_ready && !redirect;
        addr_prev = imem_addr;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          hs;
        int          since;
        logic [31:0] pc;

        rst         = 1'b0;
        imem_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        restart_stream(32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_read", 32'(imem_read), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_id_pc_plus_4", id_pc_plus_4, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);

        // Release: one BOOT cycle, then fetches from RESET_PC; fill with ID stalled
        next_cycle();
        rst        = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("boot_read", 32'(imem_read), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("first_read", 32'(imem_read), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (imem_read && imem_ready) begin
                chk("fill_addr", imem_addr, 32'(4 * hs));
                $display("fetch addr=%h q_count=%0d", imem_addr, q_count);
                hs++;
            end
        end
        chk("fill_pushes", 32'(hs), 32'd4);
        chk("fill_q_count", 32'(q_count), 32'd4);
        chk("fill_read_low", 32'(imem_read), 32'd0);
        chk("fill_id_valid", 32'(id_valid), 32'd1);

        // Drain one entry, then redirect with three entries queued
        next_cycle();
        imem_ready = 1'b0;
        id_ready   = 1'b1;
        @(negedge clk);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        restart_stream(32'h100);
        @(negedge clk);
        chk("pre_redirect_q_count", 32'(q_count), 32'd3);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("redirect_q_count", 32'(q_count), 32'd0);
        chk("redirect_addr", imem_addr, 32'h100);
        chk("redirect_read", 32'(imem_read), 32'd1);

        // Memory stall for five cycles
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            chk("stall_addr", imem_addr, 32'h100);
            chk("stall_id_valid", 32'(id_valid), 32'd0);
        end
        next_cycle();
        imem_ready = 1'b1;
        repeat (10) next_cycle();

        // Address wrap at the top of memory, and bypass / fixed-latency behaviour
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        restart_stream(32'hFFFF_FFFC);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef IF_PREFETCH_BYPASS_EN
        chk("bypass_valid", 32'(id_valid), 32'd1);
        chk("bypass_inst", id_inst, mem_word(32'hFFFF_FFFC));
        chk("bypass_pc_plus_4", id_pc_plus_4, 32'd0);
        chk("bypass_q_count", 32'(q_count), 32'd0);
`else
        chk("latency_valid_low", 32'(id_valid), 32'd0);
`endif
        next_cycle();
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'd0);
        chk("wrap_id_valid", 32'(id_valid), 32'd1);
`ifdef IF_PREFETCH_BYPASS_EN
        chk("bypass_q_count_hold", 32'(q_count), 32'd0);
`else
        chk("wrap_pc_plus_4", id_pc_plus_4, 32'd0);
`endif

        // Randomized traffic with occasional (sometimes back-to-back) redirects
        since = 0;
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            imem_ready = ($urandom_range(0, 3) != 0);
            id_ready   = 1'($urandom_range(0, 1));
            if (($urandom_range(0, 19) == 0) || (since >= 100)) begin
                if ($urandom_range(0, 3) == 0) begin
                    pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3) << 2);
                end else begin
                    pc = $urandom;
                    pc[1:0] = 2'b00;
                end
                redirect    = 1'b1;
                redirect_pc = pc;
                restart_stream(pc);
                since = 0;
                $display("redirect pc=%h", pc);
            end else begin
                redirect = 1'b0;
                since++;
            end
        end

        // Reset asserted while a request is outstanding
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        restart_stream(32'h200);
        imem_ready  = 1'b0;
        id_ready    = 1'b0;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("pre_reset_read", 32'(imem_read), 32'd1);
        next_cycle();
        imem_ready = 1'b1;
        rst        = 1'b0;
        @(negedge clk);
        chk("midrst_q_count", 32'(q_count), 32'd0);
        chk("midrst_read", 32'(imem_read), 32'd0);
        chk("midrst_id_valid", 32'(id_valid), 32'd0);
        chk("midrst_id_inst", id_inst, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_q_count", 32'(q_count), 32'd0);

        checks++;
        if (pops < 60) begin
            errors++;
            $display("FAIL consumed_words: got %0d, expected at least 60", pops);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
